// File: rtl/float_addsub_pkg.sv
// Shared types and constants for the parametrised floating-point adder/subtractor.
package float_addsub_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Positive infinity, right-aligned in a 64-bit container.
    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all-ones, fraction MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/param_float_addsub_if.sv
// Start/busy/valid handshake bundle for the FP adder; FPADD_FLAGS_EN adds the flags output.
interface param_float_addsub_if #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         valid;
    logic         busy;
`ifdef FPADD_FLAGS_EN
    logic [3:0]   flags;
`endif

    modport master (
        output start, op, a, b,
        input  sum, valid, busy
`ifdef FPADD_FLAGS_EN
        , input flags
`endif
    );

    modport slave (
        input  start, op, a, b,
        output sum, valid, busy
`ifdef FPADD_FLAGS_EN
        , output flags
`endif
    );

endinterface

// File: rtl/float_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module float_lzc #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        // NOTE: give every always_comb output a value before any branch so no latch is inferred.
        count_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/param_float_addsub.sv
// Multi-cycle FP add/sub with RNE rounding, flush-to-zero and inf/NaN handling.
// Define FPADD_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags output.
module param_float_addsub
    import float_addsub_pkg::*;
#(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input logic                clk,
    input logic                reset,
    param_float_addsub_if.slave bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 5;   // carry, hidden, fraction, G, R, S
    localparam int LZW = $clog2(SW);
    localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
    localparam logic [W-1:0]          QNAN     = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0]          PINF     = W'(fp_inf(EXP_W, MAN_W));
    localparam logic signed [XW-1:0]  EXP_ZERO = '0;
    localparam logic signed [XW-1:0]  EXP_MAX  = XW'((1 << EXP_W) - 1);

    state_e state_q, state_d;
    logic [W-1:0]          a_q, b_q, spec_val_q, sum_q;
    logic                  op_q, sign_q, sub_q, zsign_q, special_q, zero_q, uf_q, valid_q;
    logic signed [XW-1:0]  exp_q;
    logic [SW-1:0]         big_q, small_q, res_q;

    // Unpack and align.
    logic                  a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                  swap, inf_clash, special;
    logic [EXP_W-1:0]      a_exp, b_exp, big_exp, small_exp, exp_diff;
    logic [W-2:0]          a_mag, b_mag;
    logic [SW-1:0]         a_sig, b_sig, small_sig, aligned;
    logic [2*SW-1:0]       shifted;
    logic [31:0]           shamt;
    logic [W-1:0]          spec_val;

    assign a_sign    = a_q[W-1];
    assign b_sign    = b_q[W-1] ^ op_q;
    assign a_exp     = a_q[W-2:MAN_W];
    assign b_exp     = b_q[W-2:MAN_W];
    assign a_zero    = (a_exp == '0);
    assign b_zero    = (b_exp == '0);
    assign a_inf     = (a_exp == '1) && (a_q[MAN_W-1:0] == '0);
    assign b_inf     = (b_exp == '1) && (b_q[MAN_W-1:0] == '0);
    assign a_nan     = (a_exp == '1) && (a_q[MAN_W-1:0] != '0);
    assign b_nan     = (b_exp == '1) && (b_q[MAN_W-1:0] != '0);
    assign a_mag     = a_zero ? '0 : a_q[W-2:0];
    assign b_mag     = b_zero ? '0 : b_q[W-2:0];
    assign a_sig     = {1'b0, !a_zero, a_mag[MAN_W-1:0], 3'b000};
    assign b_sig     = {1'b0, !b_zero, b_mag[MAN_W-1:0], 3'b000};
    assign swap      = (b_mag > a_mag);
    assign big_exp   = swap ? b_mag[W-2:MAN_W] : a_mag[W-2:MAN_W];
    assign small_exp = swap ? a_mag[W-2:MAN_W] : b_mag[W-2:MAN_W];
    assign small_sig = swap ? a_sig : b_sig;
    assign exp_diff  = big_exp - small_exp;
    // Clamping at SW pushes every bit below the window so sticky still sees them.
    assign shamt     = (32'(exp_diff) > 32'(SW)) ? 32'(SW) : 32'(exp_diff);
    assign shifted   = {small_sig, {SW{1'b0}}} >> shamt;
    assign aligned   = shifted[2*SW-1:SW] | SW'(|shifted[SW-1:0]);
    assign inf_clash = a_inf && b_inf && (a_sign != b_sign);

    always_comb begin
        special  = 1'b1;
        spec_val = QNAN;
        if (a_nan || b_nan || inf_clash) spec_val = QNAN;
        else if (a_inf)                  spec_val = {a_sign, PINF[W-2:0]};
        else if (b_inf)                  spec_val = {b_sign, PINF[W-2:0]};
        else                             special  = 1'b0;
    end

    // Normalise.
    logic [LZW-1:0]        lz;
    logic [SW-1:0]         norm;
    logic signed [XW-1:0]  exp_n;

    float_lzc #(.WIDTH(SW - 1)) u_lzc (
        .in_i    (res_q[SW-2:0]),
        .count_o (lz)
    );

    always_comb begin
        norm  = res_q << lz;
        exp_n = exp_q - $signed(XW'(lz));
        if (res_q[SW-1]) begin
            norm  = {1'b0, res_q[SW-1:2], res_q[1] | res_q[0]};
            exp_n = exp_q + XW'(1);
        end
    end

    // Round to nearest even and assemble.
    logic                  g_bit, r_bit, s_bit, rnd_inc, ovf;
    logic [MAN_W+1:0]      mant_r;
    logic [MAN_W-1:0]      frac_r;
    logic signed [XW-1:0]  exp_r;
    logic [W-1:0]          result;

    assign g_bit   = res_q[2];
    assign r_bit   = res_q[1];
    assign s_bit   = res_q[0];
    assign rnd_inc = g_bit & (r_bit | s_bit | res_q[3]);
    assign mant_r  = {1'b0, res_q[SW-2:3]} + (MAN_W + 2)'(rnd_inc);
    assign frac_r  = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    assign exp_r   = exp_q + $signed(XW'(mant_r[MAN_W+1]));
    assign ovf     = !special_q && !zero_q && !uf_q && (exp_r >= EXP_MAX);

    always_comb begin
        result = {sign_q, exp_r[EXP_W-1:0], frac_r};
        if (special_q)   result = spec_val_q;
        else if (zero_q) result = {zsign_q, {(W-1){1'b0}}};
        else if (uf_q)   result = {sign_q, {(W-1){1'b0}}};
        else if (ovf)    result = {sign_q, PINF[W-2:0]};
    end

`ifdef FPADD_FLAGS_EN
    logic       invalid_q;
    logic [3:0] flags_q, flags_d;

    always_comb begin
        flags_d                 = '0;
        flags_d[FLAG_INVALID]   = special_q & invalid_q;
        flags_d[FLAG_OVERFLOW]  = ovf;
        flags_d[FLAG_UNDERFLOW] = !special_q && uf_q;
        flags_d[FLAG_INEXACT]   = !special_q && (g_bit | r_bit | s_bit | ovf | uf_q);
    end

    assign bus.flags = flags_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            sum_q   <= '0;
            valid_q <= 1'b0;
`ifdef FPADD_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= (state_q == ROUND);
            if (state_q == ROUND) begin
                sum_q   <= result;
`ifdef FPADD_FLAGS_EN
                flags_q <= flags_d;
`endif
            end
        end
    end

    // NOTE: pipeline datapath registers are left unreset; each is written before it is read.
    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: if (bus.start) begin
                a_q  <= bus.a;
                b_q  <= bus.b;
                op_q <= bus.op;
            end
            ALIGN: begin
                sign_q     <= swap ? b_sign : a_sign;
                sub_q      <= a_sign ^ b_sign;
                zsign_q    <= a_sign & b_sign;
                exp_q      <= $signed(XW'(big_exp));
                big_q      <= swap ? b_sig : a_sig;
                small_q    <= aligned;
                special_q  <= special;
                spec_val_q <= spec_val;
`ifdef FPADD_FLAGS_EN
                invalid_q  <= inf_clash;
`endif
            end
            ADD: res_q <= sub_q ? big_q - small_q : big_q + small_q;
            NORM: begin
                res_q  <= norm;
                exp_q  <= exp_n;
                zero_q <= (res_q == '0);
                uf_q   <= (res_q != '0) && (exp_n <= EXP_ZERO);
            end
            default: ;
        endcase
    end

    assign bus.sum   = sum_q;
    assign bus.valid = valid_q;
    assign bus.busy  = (state_q inside {ALIGN, ADD, NORM, ROUND});

endmodule

// File: tb/tb_param_float_addsub.sv
// Directed bench for param_float_addsub at EXP_W=3, MAN_W=4 (bias 3).
module tb_param_float_addsub;

    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int NV    = 20;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    param_float_addsub_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    param_float_addsub #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // flags = {invalid, overflow, underflow, inexact}
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] sum;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int   n     = 0;
        int   nbusy = 0;
        logic seen  = 1'b0;
        @(negedge clk);
        bus.a     = v.a;
        bus.b     = v.b;
        bus.op    = v.op;
        bus.start = 1'b1;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
            if (bus.busy) nbusy++;
            seen = bus.valid;
        end
        check({tag, "/latency"}, n, 5);
        check({tag, "/busy_cycles"}, nbusy, 4);
        check({tag, "/sum"}, bus.sum, v.sum);
`ifdef FPADD_FLAGS_EN
        check({tag, "/flags"}, bus.flags, v.flags);
`endif
        @(posedge clk);
        #1;
        check({tag, "/valid_one_cycle"}, bus.valid, 0);
    endtask

    initial begin
        int first_v, second_v, nvalid;
        logic [7:0] sum1, sum2;

        vecs = '{
            '{8'h30, 8'h30, 1'b0, 8'h40, 4'h0},  // 1.0 + 1.0
            '{8'h38, 8'h38, 1'b0, 8'h48, 4'h0},  // 1.5 + 1.5
            '{8'h60, 8'h10, 1'b0, 8'h60, 4'h1},  // tie, even stays
            '{8'h61, 8'h10, 1'b0, 8'h62, 4'h1},  // tie, odd rounds up
            '{8'h60, 8'h11, 1'b0, 8'h61, 4'h1},  // above half via sticky
            '{8'h30, 8'h30, 1'b1, 8'h00, 4'h0},  // x - x
            '{8'hB0, 8'h30, 1'b0, 8'h00, 4'h0},  // -1 + 1
            '{8'h30, 8'h40, 1'b1, 8'hB0, 4'h0},  // 1 - 2
            '{8'h30, 8'hB8, 1'b0, 8'hA0, 4'h0},  // 1 + -1.5
            '{8'h5F, 8'h10, 1'b0, 8'h60, 4'h0},  // carry-out renormalise
            '{8'h6F, 8'h6F, 1'b0, 8'h70, 4'h5},  // overflow after normalise
            '{8'h6F, 8'h10, 1'b0, 8'h70, 4'h5},  // overflow after rounding
            '{8'h18, 8'h14, 1'b1, 8'h00, 4'h3},  // underflow flush
            '{8'h70, 8'h70, 1'b1, 8'h78, 4'h8},  // inf - inf
            '{8'h71, 8'h30, 1'b0, 8'h78, 4'h0},  // NaN input
            '{8'h70, 8'h30, 1'b0, 8'h70, 4'h0},  // +inf + finite
            '{8'hF0, 8'h30, 1'b0, 8'hF0, 4'h0},  // -inf + finite
            '{8'h80, 8'h80, 1'b0, 8'h80, 4'h0},  // -0 + -0
            '{8'h80, 8'h00, 1'b1, 8'h80, 4'h0},  // -0 - +0
            '{8'h80, 8'h00, 1'b0, 8'h00, 4'h0}   // -0 + +0
        };

        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset/sum", bus.sum, 0);
        check("reset/valid", bus.valid, 0);
        check("reset/busy", bus.busy, 0);
`ifdef FPADD_FLAGS_EN
        check("reset/flags", bus.flags, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // start held high: the second op is taken only from IDLE after DONE.
        first_v = 0; second_v = 0; nvalid = 0; sum1 = '0; sum2 = '0;
        @(negedge clk);
        bus.a = 8'h30; bus.b = 8'h30; bus.op = 1'b0; bus.start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin bus.a = 8'h38; bus.b = 8'h38; end
            if (n == 6) check("b2b/idle_busy", bus.busy, 0);
            if (n == 12) bus.start = 1'b0;
            if (bus.valid) begin
                nvalid++;
                if (first_v == 0) begin first_v = n; sum1 = bus.sum; end
                else begin second_v = n; sum2 = bus.sum; end
            end
        end
        check("b2b/first_latency", first_v, 5);
        check("b2b/first_sum", sum1, 8'h40);
        check("b2b/second_latency", second_v, 11);
        check("b2b/second_sum", sum2, 8'h48);
        check("b2b/valid_count", nvalid, 2);
        repeat (8) @(posedge clk);

        // Reset while in NORM aborts the operation.
        @(negedge clk);
        bus.a = 8'h38; bus.b = 8'h30; bus.op = 1'b0; bus.start = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check("abort/in_norm_busy", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort/valid", bus.valid, 0);
        check("abort/sum", bus.sum, 0);
        check("abort/busy", bus.busy, 0);
        reset  = 1'b0;
        nvalid = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (bus.valid) nvalid++;
        end
        check("abort/no_valid", nvalid, 0);
        run_op("after_abort", vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
